// File: rtl/sfd_pkg.sv
// Shared types and constants for the serial frame deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sfd_pkg;

    // Framing state: searching for sync, or collecting frame words.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Width of the sync pattern window.
    localparam int SYNC_W = 8;

    // Number of entries in the output word buffer.
    localparam int FIFO_DEPTH = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_frame_deser_if.sv
// Serial input plus word-stream output of the frame deserializer.
// Latency: n/a (wiring only).
// Backpressure: m_ready from the consumer throttles m_valid/m_data.
interface serial_frame_deser_if #(
    parameter int WIDTH = 8
);
    logic             D;
    logic             D_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    // Deserializer side: consumes serial bits, produces the word stream.
    modport master (
        input  D,
        input  D_valid,
        output m_data,
        output m_valid,
        input  m_ready
    );

    // Source/consumer side: drives serial bits, accepts the word stream.
    modport slave (
        output D,
        output D_valid,
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/sfd_out_buf.sv
// Two-entry word FIFO holding completed words for the output stream.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: a push while full is ignored unless a pop frees a slot that same cycle.
module sfd_out_buf
    import sfd_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = cnt_width(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_en;
    logic             rd_en;

    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    // A simultaneous pop makes room, so a push onto a full buffer still lands.
    assign wr_en    = push && (!full || pop);
    assign rd_en    = pop && !empty;
    assign head_dat = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/serial_frame_deser.sv
// Hunts a serial bit stream for SYNC, then assembles FRAME_WORDS words MSB-first per frame.
// Latency: a completed word reaches m_valid/m_data one cycle after its last bit (buffer empty).
// Backpressure: 2-entry output buffer; a word completing into a full buffer with no pop is dropped and flags overflow.
module serial_frame_deser
    import sfd_pkg::*;
#(
    parameter int                WIDTH       = 8,
    parameter logic [SYNC_W-1:0] SYNC        = 8'hA5,
    parameter int                FRAME_WORDS = 4
)(
    input  logic                  clk1,
    input  logic                  rst_n,
    serial_frame_deser_if.master  bus,
    output logic                  locked,
    output logic                  frame_start,
    output logic                  overflow
);
    localparam int BIT_W = cnt_width(WIDTH);
    localparam int WC_W  = cnt_width(FRAME_WORDS);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(FRAME_WORDS - 1);

    state_t            state_q;
    logic [SYNC_W-1:0] sync_q;
    logic [SYNC_W-1:0] sync_d;
    logic [WIDTH-1:0]  word_q;
    logic [WIDTH-1:0]  word_d;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [WC_W-1:0]   word_cnt_q;
    logic              frame_start_q;
    logic              overflow_q;

    logic              word_done;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WIDTH-1:0]  head_dat;

    // Bits shifted out past the MSB of either register are meant to be lost.
    logic              unused_msbs;
    assign unused_msbs = ^{sync_q[SYNC_W-1], word_q[WIDTH-1]};

    // Post-shift views: the new bit enters at bit 0 so the first bit ends up as MSB.
    assign sync_d    = {sync_q[SYNC_W-2:0], bus.D};
    assign word_d    = {word_q[WIDTH-2:0], bus.D};
    assign word_done = (state_q == LOCKED) && bus.D_valid && (bit_cnt_q == BIT_LAST);
    assign pop       = !fifo_empty && bus.m_ready;

    sfd_out_buf #(
        .WIDTH    (WIDTH)
    ) u_out_buf (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .push     (word_done),
        .push_dat (word_d),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Framing FSM: sync hunt, bit/word counting and the frame_start pulse; idle bits freeze everything.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            sync_q        <= '0;
            word_q        <= '0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (bus.D_valid) begin
                case (state_q)
                    HUNT: begin
                        if (sync_d == SYNC) begin
                            state_q       <= LOCKED;
                            sync_q        <= '0;
                            bit_cnt_q     <= '0;
                            word_cnt_q    <= '0;
                            frame_start_q <= 1'b1;
                        end else begin
                            sync_q <= sync_d;
                        end
                    end
                    LOCKED: begin
                        word_q <= word_d;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            if (word_cnt_q == WORD_LAST) begin
                                // Back to hunting with an empty window so stale frame bits cannot match.
                                state_q    <= HUNT;
                                word_cnt_q <= '0;
                                sync_q     <= '0;
                            end else begin
                                word_cnt_q <= word_cnt_q + 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                        sync_q  <= '0;
                    end
                endcase
            end
        end
    end

    // Sticky drop flag: a word completed into a full buffer that was not draining.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (word_done && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign frame_start = frame_start_q;
    assign overflow    = overflow_q;
    assign bus.m_valid = !fifo_empty;
    assign bus.m_data  = head_dat;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Randomized and directed stimulus against a bit-stream reference model with a scoreboard.
// Latency: model predicts per-edge state; the monitor compares on the falling edge.
// Backpressure: m_ready is driven directly, including randomly toggled phases.
module tb_serial_frame_deser;

    localparam int         W      = 8;
    localparam logic [7:0] SYNC_P = 8'hA5;
    localparam int         FW     = 4;
    localparam int         DEPTH  = 2;

    logic clk1 = 1'b0;
    logic rst_n;
    logic locked;
    logic frame_start;
    logic overflow;

    always #5 clk1 = ~clk1;

    serial_frame_deser_if #(.WIDTH(W)) bus ();

    serial_frame_deser #(
        .WIDTH       (W),
        .SYNC        (SYNC_P),
        .FRAME_WORDS (FW)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .bus         (bus),
        .locked      (locked),
        .frame_start (frame_start),
        .overflow    (overflow)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: state after the upcoming clock edge.
    bit   m_hunt;
    int   m_win;
    int   m_word;
    int   m_nbits;
    int   m_nwords;
    int   m_occ;
    bit   m_fs;
    bit   m_ovf;
    logic [7:0] exp_q[$];

    // Snapshot of the model for the edge that just happened.
    bit   cur_locked;
    bit   cur_fs;
    bit   cur_ovf;
    int   cur_occ;
    bit   chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hunt = 1'b1; m_win = 0; m_word = 0; m_nbits = 0; m_nwords = 0;
        m_occ = 0; m_fs = 1'b0; m_ovf = 1'b0;
        exp_q.delete();
    endtask

    task automatic commit();
        cur_locked = !m_hunt;
        cur_fs     = m_fs;
        cur_ovf    = m_ovf;
        cur_occ    = m_occ;
    endtask

    // One clock edge worth of behaviour, from the frame rules.
    task automatic step(input bit v, input bit d, input bit rdy);
        bit complete;
        int wd;
        bit pop;
        complete = 1'b0;
        wd       = 0;
        pop      = (m_occ > 0) && rdy;
        m_fs     = 1'b0;
        if (v) begin
            if (m_hunt) begin
                m_win = ((m_win << 1) | int'(d)) & 8'hFF;
                if (m_win == int'(SYNC_P)) begin
                    m_hunt = 1'b0; m_win = 0; m_nbits = 0; m_nwords = 0; m_fs = 1'b1;
                end
            end else begin
                m_word = ((m_word << 1) | int'(d)) & ((1 << W) - 1);
                m_nbits++;
                if (m_nbits == W) begin
                    complete = 1'b1;
                    wd       = m_word;
                    m_nbits  = 0;
                    m_nwords++;
                    if (m_nwords == FW) begin
                        m_hunt = 1'b1; m_win = 0; m_nwords = 0;
                    end
                end
            end
        end
        if (pop) m_occ--;
        if (complete) begin
            if (m_occ < DEPTH) begin
                m_occ++;
                exp_q.push_back(wd[7:0]);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic drive(input bit v, input bit d, input bit rdy);
        @(posedge clk1);
        #2;
        commit();
        bus.D_valid = v;
        bus.D       = d;
        bus.m_ready = rdy;
        step(v, d, rdy);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rdy, input bit rdy_last, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            if (gaps) drive(1'b0, 1'b1, rdy);
            drive(1'b1, b[i], (i == 0) ? rdy_last : rdy);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) drive(1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        @(posedge clk1);
        #2;
        rst_n       = 1'b0;
        bus.D_valid = 1'b0;
        bus.D       = 1'b0;
        #1;
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        model_reset();
        commit();
        repeat (2) @(posedge clk1);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 50) begin
            drive(1'b0, 1'b0, 1'b1);
            k++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
        end
    endtask

    // Monitor: per-cycle status against the model, data against the scoreboard on each transfer.
    always @(negedge clk1) begin
        if (chk_en && rst_n) begin
            check("locked", 32'(locked), 32'(cur_locked));
            check("frame_start", 32'(frame_start), 32'(cur_fs));
            check("overflow", 32'(overflow), 32'(cur_ovf));
            check("m_valid", 32'(bus.m_valid), 32'(cur_occ > 0));
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL m_data: unexpected word %0h, expected none", bus.m_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("m_data", 32'(bus.m_data), 32'(e));
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        bus.D       = 1'b0;
        bus.D_valid = 1'b0;
        bus.m_ready = 1'b0;
        model_reset();
        commit();
        do_reset();
        chk_en = 1'b1;

        // Sync then 0x3C, 0xC3, then finish the frame.
        send_byte(SYNC_P, 1'b1, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b1, 1'b0);
        send_byte(8'hC3, 1'b1, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Full frame 01..04, then a stray byte while hunting must produce nothing.
        send_byte(SYNC_P, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 1'b1, 1'b0);
        send_byte(8'h01, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Gapped bits inside words.
        send_byte(SYNC_P, 1'b1, 1'b1, 1'b0);
        send_byte(8'h5A, 1'b1, 1'b1, 1'b1);
        send_byte(8'h3C, 1'b1, 1'b1, 1'b1);
        send_byte(8'h96, 1'b1, 1'b1, 1'b0);
        send_byte(8'h69, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Buffer full, consumer ready exactly as the third word completes.
        send_byte(SYNC_P, 1'b0, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0, 1'b0);
        send_byte(8'h66, 1'b0, 1'b0, 1'b0);
        send_byte(8'h77, 1'b0, 1'b1, 1'b0);
        send_byte(8'h88, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Stalled consumer: third and fourth words dropped, overflow sticks.
        send_byte(SYNC_P, 1'b0, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        drain();
        idle(2, 1'b1);

        // Reset mid-frame after five bits of the second word.
        send_byte(SYNC_P, 1'b1, 1'b1, 1'b0);
        send_byte(8'h12, 1'b1, 1'b1, 1'b0);
        begin
            logic [7:0] pb;
            pb = 8'h34;
            for (int i = 7; i >= 3; i--) drive(1'b1, pb[i], 1'b1);
        end
        do_reset();
        send_byte(8'h56, 1'b1, 1'b1, 1'b0);
        send_byte(8'h78, 1'b1, 1'b1, 1'b0);
        send_byte(SYNC_P, 1'b1, 1'b1, 1'b0);
        send_byte(8'h9A, 1'b1, 1'b1, 1'b0);
        send_byte(8'hBC, 1'b1, 1'b1, 1'b0);
        send_byte(8'hDE, 1'b1, 1'b1, 1'b0);
        send_byte(8'hF0, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Random traffic: sync-heavy bytes, random gaps, random consumer stalls.
        for (int n = 0; n < 60; n++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 3) == 0) ? SYNC_P : 8'($urandom_range(0, 255));
            for (int i = 7; i >= 0; i--) begin
                while ($urandom_range(0, 2) == 0)
                    drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                drive(1'b1, b[i], 1'($urandom_range(0, 1)));
            end
        end
        drain();
        idle(2, 1'b1);

        @(negedge clk1);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_frame_deser.md
SERIAL_FRAME_DESER -- requirements
Module: serial_frame_deser

Interface
REQ-001 Parameter WIDTH, default 8, number of bits per output word.
REQ-002 Parameter SYNC, default 8'hA5, 8-bit frame sync pattern.
REQ-003 Parameter FRAME_WORDS, default 4, number of words collected per frame after sync.
REQ-004 clk1  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 D  input  1  serial data bit, qualified by D_valid.
REQ-007 D_valid  input  1  D carries a valid bit this cycle.
REQ-008 m_data  output  WIDTH  assembled word at buffer head.
REQ-009 m_valid  output  1  m_data holds a valid word.
REQ-010 m_ready  input  1  consumer accepts m_data this cycle.
REQ-011 locked  output  1  high while in LOCKED state.
REQ-012 frame_start  output  1  one-cycle pulse on sync detection.
REQ-013 overflow  output  1  sticky flag, a completed word was dropped.

Function
REQ-014 Two states, HUNT and LOCKED; locked SHALL be 1 exactly in LOCKED.
REQ-015 Shift order: on each D_valid cycle, the active shift register shifts left, with D entering bit 0, so the first bit received ends up as MSB.
REQ-016 HUNT: 8-bit sync window shifts on D_valid; when the post-shift window equals SYNC, next state SHALL be LOCKED, with bit_cnt=0, word_cnt=0, and frame_start=1 for that following cycle only.
REQ-017 Sync window SHALL be cleared to 0 on every entry to HUNT, so bits from the previous frame cannot form a match.
REQ-018 LOCKED: bits shift into word register; bit_cnt counts 0..WIDTH-1 and wraps to 0 on the WIDTH-th valid bit, which completes a word.
REQ-019 Cycles with D_valid=0 SHALL leave all shift registers and counters unchanged in both states.
REQ-020 On word completion, the word SHALL be pushed to the output buffer and visible on m_data/m_valid the cycle after the completing bit (latency 1) when the buffer was empty.
REQ-021 On the completion of word FRAME_WORDS (word_cnt == FRAME_WORDS-1), next state SHALL be HUNT; otherwise word_cnt increments.
REQ-022 Output buffer SHALL be a 2-entry FIFO; transfer occurs when m_valid && m_ready; m_data SHALL stay stable while m_valid && !m_ready.
REQ-023 Push when full with no simultaneous pop: the word SHALL be dropped, overflow SHALL be set, and the state machine SHALL continue unaffected.
REQ-024 Push when full with a simultaneous pop SHALL be accepted; no overflow.
REQ-025 overflow SHALL clear only on reset.
REQ-026 m_ready while m_valid=0 SHALL have no effect.

Reset
REQ-027 rst_n low SHALL asynchronously force: state HUNT, sync window 0, word register 0, counters 0, FIFO empty, m_valid 0, m_data 0, locked 0, frame_start 0, overflow 0.
REQ-028 Reset asserted mid-frame SHALL discard any partial word and all buffered words; after release, the block SHALL require a fresh SYNC match.

Structure
REQ-029 Package sfd_pkg SHALL hold the state enum (HUNT, LOCKED), the SYNC width constant (8), and the FIFO depth constant (2).
REQ-030 The output FIFO SHALL be a sub-module sfd_out_buf (WIDTH-parameterised, 2 entries, push/pop/full/empty, same clk1/rst_n).

Verification
REQ-031 Bits 1010_0101 then 16 bits 0x3C,0xC3, with m_ready=1: frame_start pulses once, m_data shows 8'h3C then 8'hC3, each valid 1 cycle after its last bit.
REQ-032 SYNC plus 4 words 0x01..0x04 with m_ready=1: locked drops after the 4th word; a following 0x01 bit pattern yields no output until a new A5.
REQ-033 D_valid toggled 1/0 every cycle during a word: same m_data as the contiguous case; completion is delayed only by the gap cycles.
REQ-034 m_ready=0 for 3 words (0x11,0x22,0x33): 0x11 and 0x22 are held; 0x33 is dropped; overflow=1; then m_ready=1 drains 0x11 then 0x22.
REQ-035 FIFO full and m_ready=1 in the cycle the 3rd word completes: all 3 words are delivered in order; overflow stays 0.
REQ-036 rst_n pulsed low after 5 bits of word 2: all outputs return to 0 immediately; the next valid word appears only after a new SYNC.
